// File: rtl/fir_mdc_tcdm_arbiter.sv
// Round-robin merge of MP accelerator TCDM master ports onto one bank port.
// Granted master IDs are queued in order so in-order responses return to their owner.
module fir_mdc_tcdm_arbiter #(
  parameter int unsigned MP          = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [MP-1:0]    mst_req_i,
  input  logic [MP*32-1:0] mst_add_i,
  input  logic [MP-1:0]    mst_wen_i,
  input  logic [MP*4-1:0]  mst_be_i,
  input  logic [MP*32-1:0] mst_data_i,
  output logic [MP-1:0]    mst_gnt_o,
  output logic [MP*32-1:0] mst_r_data_o,
  output logic [MP-1:0]    mst_r_valid_o,
  output logic             slv_req_o,
  output logic [31:0]      slv_add_o,
  output logic             slv_wen_o,
  output logic [3:0]       slv_be_o,
  output logic [31:0]      slv_data_o,
  input  logic             slv_gnt_i,
  input  logic [31:0]      slv_r_data_i,
  input  logic             slv_r_valid_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned IDW = $clog2(MP);
  localparam int unsigned PW  = $clog2(OUTSTANDING);
  localparam int unsigned CW  = PW + 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_mem_q [OUTSTANDING];
  logic [IDW-1:0] id_mem_d [OUTSTANDING];
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [IDW-1:0] sel_id, cand, head;
  logic           any_req, full, push, pop;

  // Search from ptr upward, wrapping at MP-1; first requester wins.
  always_comb begin
    sel_id  = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < MP; i++) begin
      cand = IDW'((32'(ptr_q) + i) % MP);
      if (!any_req && mst_req_i[cand]) begin
        any_req = 1'b1;
        sel_id  = cand;
      end
    end
  end

  // A full queue blocks new requests even if a response frees a slot this cycle.
  assign full      = (cnt_q == CW'(OUTSTANDING));
  assign slv_req_o = any_req && !full && !rst_i;
  assign push      = slv_req_o && slv_gnt_i;
  assign pop       = slv_r_valid_i && (cnt_q != '0);
  assign head      = id_mem_q[rd_q];

  always_comb begin
    slv_add_o     = '0;
    slv_wen_o     = 1'b0;
    slv_be_o      = '0;
    slv_data_o    = '0;
    mst_gnt_o     = '0;
    mst_r_valid_o = '0;
    for (int unsigned k = 0; k < MP; k++) begin
      if (slv_req_o && (sel_id == IDW'(k))) begin
        slv_add_o    = mst_add_i[k*32 +: 32];
        slv_wen_o    = mst_wen_i[k];
        slv_be_o     = mst_be_i[k*4 +: 4];
        slv_data_o   = mst_data_i[k*32 +: 32];
        mst_gnt_o[k] = slv_gnt_i;
      end
      mst_r_valid_o[k] = pop && (head == IDW'(k));
    end
  end

  assign mst_r_data_o = {MP{slv_r_data_i}};
  assign busy_o       = (cnt_q != '0);
  assign err_o        = err_q;

  always_comb begin
    ptr_d    = ptr_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    id_mem_d = id_mem_q;
    if (push) begin
      ptr_d          = (sel_id == IDW'(MP - 1)) ? '0 : sel_id + 1'b1;
      id_mem_d[wr_q] = sel_id;
      wr_d           = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Registered so the violation pulse is a clean single cycle after the stray response.
    err_d = slv_r_valid_i && (cnt_q == '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned j = 0; j < OUTSTANDING; j++) id_mem_q[j] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      id_mem_q <= id_mem_d;
    end
  end

endmodule

// File: tb/tb_fir_mdc_tcdm_arbiter.sv
// Bench for fir_mdc_tcdm_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fir_mdc_tcdm_arbiter;
  localparam int MP  = 2;
  localparam int OUT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [MP-1:0]    mst_req_i = '0;
  logic [MP*32-1:0] mst_add_i = '0;
  logic [MP-1:0]    mst_wen_i = '0;
  logic [MP*4-1:0]  mst_be_i = '0;
  logic [MP*32-1:0] mst_data_i = '0;
  logic [MP-1:0]    mst_gnt_o;
  logic [MP*32-1:0] mst_r_data_o;
  logic [MP-1:0]    mst_r_valid_o;
  logic             slv_req_o;
  logic [31:0]      slv_add_o;
  logic             slv_wen_o;
  logic [3:0]       slv_be_o;
  logic [31:0]      slv_data_o;
  logic             slv_gnt_i = 1'b0;
  logic [31:0]      slv_r_data_i = '0;
  logic             slv_r_valid_i = 1'b0;
  logic             busy_o;
  logic             err_o;

  fir_mdc_tcdm_arbiter #(.MP(MP), .OUTSTANDING(OUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(mst_req_i), .mst_add_i(mst_add_i), .mst_wen_i(mst_wen_i),
    .mst_be_i(mst_be_i), .mst_data_i(mst_data_i),
    .mst_gnt_o(mst_gnt_o), .mst_r_data_o(mst_r_data_o), .mst_r_valid_o(mst_r_valid_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o),
    .slv_be_o(slv_be_o), .slv_data_o(slv_data_o),
    .slv_gnt_i(slv_gnt_i), .slv_r_data_i(slv_r_data_i), .slv_r_valid_i(slv_r_valid_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ID queue of granted masters, round-robin pointer, pending error flag.
  int m_q[$];
  int m_ptr = 0;
  bit m_err = 0;

  function automatic int pick(input int p, input logic [MP-1:0] r);
    for (int i = 0; i < MP; i++) begin
      if (r[(p + i) % MP]) return (p + i) % MP;
    end
    return -1;
  endfunction

  int u_k;
  bit u_hs, u_pop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ptr = 0;
      m_err = 0;
    end else begin
      u_k   = pick(m_ptr, mst_req_i);
      u_hs  = (u_k >= 0) && (m_q.size() < OUT) && slv_gnt_i;
      u_pop = slv_r_valid_i && (m_q.size() > 0);
      m_err = slv_r_valid_i && (m_q.size() == 0);
      if (u_pop) void'(m_q.pop_front());
      if (u_hs) begin
        m_q.push_back(u_k);
        m_ptr = (u_k + 1) % MP;
      end
    end
  end

  int c_k;
  bit c_req;
  logic [MP-1:0] c_gnt, c_rv;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_slv_req", 32'(slv_req_o), 0);
      chk("rst_gnt", 32'(mst_gnt_o), 0);
      chk("rst_rvalid", 32'(mst_r_valid_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_err", 32'(err_o), 0);
    end else begin
      c_k   = pick(m_ptr, mst_req_i);
      c_req = (c_k >= 0) && (m_q.size() < OUT);
      c_gnt = (c_req && slv_gnt_i) ? MP'(1 << c_k) : '0;
      c_rv  = (slv_r_valid_i && m_q.size() > 0) ? MP'(1 << m_q[0]) : '0;
      chk("slv_req", 32'(slv_req_o), 32'(c_req));
      chk("mst_gnt", 32'(mst_gnt_o), 32'(c_gnt));
      chk("slv_add", slv_add_o, c_req ? mst_add_i[c_k*32 +: 32] : 32'h0);
      chk("slv_wen", 32'(slv_wen_o), c_req ? 32'(mst_wen_i[c_k]) : 0);
      chk("slv_be", 32'(slv_be_o), c_req ? 32'(mst_be_i[c_k*4 +: 4]) : 0);
      chk("slv_data", slv_data_o, c_req ? mst_data_i[c_k*32 +: 32] : 32'h0);
      chk("mst_r_valid", 32'(mst_r_valid_o), 32'(c_rv));
      for (int i = 0; i < MP; i++) chk("mst_r_data", mst_r_data_o[i*32 +: 32], slv_r_data_i);
      chk("busy", 32'(busy_o), 32'(m_q.size() != 0));
      chk("err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("lit_rst_req", 32'(slv_req_o), 0);
    chk("lit_rst_busy", 32'(busy_o), 0);
    cyc();
    rst = 1'b0;

    // Two masters requesting continuously, 1-cycle bank response
    mst_add_i = {32'h0000_1004, 32'h0000_1000};
    mst_req_i = 2'b11;
    slv_gnt_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lit_alt_gnt", 32'(mst_gnt_o), (i % 2) ? 32'h2 : 32'h1);
      if (i > 0) chk("lit_alt_rvalid", 32'(mst_r_valid_o), (i % 2) ? 32'h1 : 32'h2);
      cyc();
      slv_r_valid_i = 1'b1;
      slv_r_data_i  = 32'hA000 + 32'(i);
    end
    mst_req_i = '0;
    @(negedge clk);
    chk("lit_alt_last_rvalid", 32'(mst_r_valid_o), 32'h2);
    cyc();
    slv_r_valid_i = 1'b0;

    // Fill the queue from master 0 with no responses
    mst_req_i = 2'b01;
    for (int i = 0; i < OUT; i++) begin
      @(negedge clk);
      chk("lit_fill_gnt", 32'(mst_gnt_o), 32'h1);
      cyc();
    end
    @(negedge clk);
    chk("lit_full_req", 32'(slv_req_o), 0);
    chk("lit_full_busy", 32'(busy_o), 1);
    chk("lit_full_gnt", 32'(mst_gnt_o), 0);
    cyc();
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = 32'h5555_AAAA;
    @(negedge clk);
    chk("lit_fullpop_req", 32'(slv_req_o), 0);
    chk("lit_fullpop_rvalid", 32'(mst_r_valid_o), 32'h1);
    cyc();
    slv_r_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_after_pop_req", 32'(slv_req_o), 1);
    chk("lit_after_pop_gnt", 32'(mst_gnt_o), 32'h1);
    cyc();
    mst_req_i = '0;
    slv_r_valid_i = 1'b1;
    for (int i = 0; i < OUT; i++) begin
      @(negedge clk);
      chk("lit_drain_rvalid", 32'(mst_r_valid_o), 32'h1);
      cyc();
    end
    slv_r_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_drained_busy", 32'(busy_o), 0);

    // Stray response with empty queue
    cyc();
    slv_r_valid_i = 1'b1;
    @(negedge clk);
    chk("lit_stray_rvalid", 32'(mst_r_valid_o), 0);
    chk("lit_stray_err_pre", 32'(err_o), 0);
    cyc();
    slv_r_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_stray_err", 32'(err_o), 1);
    cyc();
    @(negedge clk);
    chk("lit_stray_err_post", 32'(err_o), 0);

    // Stalled bank: fields stable, master 0 first, ptr moves only on handshake
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    mst_add_i  = {32'h0000_0100, 32'h0000_0200};
    mst_wen_i  = 2'b10;
    mst_be_i   = {4'hF, 4'hF};
    mst_data_i = {32'h0, 32'hDEAD_BEEF};
    mst_req_i  = 2'b11;
    slv_gnt_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_stall_gnt", 32'(mst_gnt_o), 0);
      chk("lit_stall_add", slv_add_o, 32'h200);
      chk("lit_stall_wen", 32'(slv_wen_o), 0);
      chk("lit_stall_be", 32'(slv_be_o), 32'hF);
      chk("lit_stall_data", slv_data_o, 32'hDEAD_BEEF);
      cyc();
    end
    slv_gnt_i = 1'b1;
    @(negedge clk);
    chk("lit_unstall_gnt0", 32'(mst_gnt_o), 32'h1);
    cyc();
    @(negedge clk);
    chk("lit_unstall_gnt1", 32'(mst_gnt_o), 32'h2);
    chk("lit_unstall_add1", slv_add_o, 32'h100);
    chk("lit_unstall_wen1", 32'(slv_wen_o), 1);
    cyc();

    // Third outstanding, then asynchronous reset mid-cycle
    mst_req_i = 2'b01;
    @(negedge clk);
    chk("lit_third_gnt", 32'(mst_gnt_o), 32'h1);
    cyc();
    mst_req_i = 2'b11;
    slv_gnt_i = 1'b0;
    @(negedge clk);
    chk("lit_pre_rst_busy", 32'(busy_o), 1);
    chk("lit_pre_rst_req", 32'(slv_req_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("lit_async_req", 32'(slv_req_o), 0);
    chk("lit_async_busy", 32'(busy_o), 0);
    chk("lit_async_gnt", 32'(mst_gnt_o), 0);
    chk("lit_async_rvalid", 32'(mst_r_valid_o), 0);
    cyc();
    rst = 1'b0;
    slv_gnt_i = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_gnt", 32'(mst_gnt_o), 32'h1);
    chk("lit_post_rst_busy", 32'(busy_o), 0);
    cyc();
    mst_req_i = '0;
    slv_r_valid_i = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_rvalid", 32'(mst_r_valid_o), 32'h1);
    cyc();
    @(negedge clk);
    chk("lit_late_rvalid", 32'(mst_r_valid_o), 0);
    cyc();
    slv_r_valid_i = 1'b0;
    @(negedge clk);
    chk("lit_late_err", 32'(err_o), 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
